// File: rtl/seq_isqrt.sv
// seq_isqrt: iterative unsigned integer square root using the restoring
// digit-by-digit method, producing one root bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset
//   in_valid   radicand offered
//   in_ready   unit can accept a radicand (IDLE only)
//   x          unsigned radicand, WIDTH bits
//   out_valid  result held and valid (DONE)
//   out_ready  consumer accepts the result
//   root       floor(sqrt(x)), WIDTH/2 bits
//   rem        x - root*root, WIDTH/2+1 bits (only with SQRT_REM_EN)
//
// Configuration macro: SQRT_REM_EN exposes the remainder port. Without it the
// remainder register still exists because the recurrence needs it.
//
// Parameter WIDTH must be even and >= 4.

module seq_isqrt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2-1:0]   root
`ifdef SQRT_REM_EN
  ,
  output logic [WIDTH/2:0]     rem
`endif
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned RW = HW + 2;
  localparam int unsigned CW = (HW > 1) ? $clog2(HW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] xs, xs_nxt;
  logic [HW-1:0]    q, q_nxt;
  logic [HW:0]      r, r_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             in_ready_nxt;
  logic             out_valid_nxt;

  // Trial subtract: r' - t as r' + ~t + 1; the carry-out means r' >= t.
  logic [RW-1:0]    r_sh;
  logic [RW-1:0]    t;
  logic [RW:0]      sum;
  logic             carry;
  logic [HW:0]      r_step;

  always_comb begin
    r_sh   = {r[HW-1:0], xs[WIDTH-1 -: 2]};
    t      = {q, 2'b01};
    sum    = {1'b0, r_sh} + {1'b0, ~t} + (RW+1)'(1);
    carry  = sum[RW];
    // Both candidates are bounded by 2*root, so the top bit of each is zero.
    r_step = carry ? sum[HW:0] : r_sh[HW:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xs        <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      xs        <= xs_nxt;
      q         <= q_nxt;
      r         <= r_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_nxt     = state;
    xs_nxt        = xs;
    q_nxt         = q;
    r_nxt         = r;
    cnt_nxt       = cnt;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;

    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          xs_nxt       = x;
          q_nxt        = '0;
          r_nxt        = '0;
          cnt_nxt      = CW'(HW - 1);
          in_ready_nxt = 1'b0;
          state_nxt    = CALC;
        end
      end
      CALC: begin
        xs_nxt = {xs[WIDTH-3:0], 2'b00};
        q_nxt  = {q[HW-2:0], carry};
        r_nxt  = r_step;
        if (cnt == '0) begin
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // Root and remainder registers are only updated in CALC, so they hold in DONE.
  assign root = q;

`ifdef SQRT_REM_EN
  assign rem = r;
  logic unused_bits;
  assign unused_bits = ^{sum[RW-1], r_sh[RW-1]};
`else
  logic unused_bits;
  assign unused_bits = ^{sum[RW-1], r_sh[RW-1], r[HW]};
`endif

endmodule

// File: tb/tb_seq_isqrt.sv
// Testbench for seq_isqrt: directed boundary cases, back-pressure, back-to-back,
// reset mid-operation and a random sweep, all scored against a behavioural
// square-root model.

module tb_seq_isqrt;

  localparam int unsigned W  = 16;
  localparam int unsigned HW = W / 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic            out_valid;
  logic            out_ready;
  logic [HW-1:0]   root;
`ifdef SQRT_REM_EN
  logic [HW:0]     rem;
`endif

  seq_isqrt #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root)
`ifdef SQRT_REM_EN
    ,
    .rem       (rem)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic bp_mode   = 1'b0;
  logic rnd_ready = 1'b1;
  logic out_drv   = 1'b1;

  assign out_ready = bp_mode ? rnd_ready : out_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout want event (cycle %0d)", name, cyc);
  endtask

  // Reference: largest r with r*r <= v, found by binary search.
  function automatic void model(input longint unsigned v,
                                output longint unsigned rt,
                                output longint unsigned rm);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = (longint'(1) << HW) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    rt = lo;
    rm = v - lo * lo;
  endfunction

  // Scoreboard of accepted radicands and the negedge cycle they were seen at.
  longint unsigned exp_q[$];
  int              t_q[$];
  logic            ov_prev = 1'b0;

  // Single compare process: every cycle out_valid is high the outputs must match the model.
  always @(negedge clk) begin
    longint unsigned rt, rm;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(longint'(x));
        t_q.push_back(cyc);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          model(exp_q[0], rt, rm);
          check("model_root", longint'(root), rt);
`ifdef SQRT_REM_EN
          check("model_rem", longint'(rem), rm);
`endif
          check("in_ready_in_done", longint'(in_ready), 0);
          if (!ov_prev) check("latency", longint'(cyc - t_q[0]), HW + 1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
          end
        end
      end
      ov_prev = out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] v);
    bit got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x        = v;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) bound_fail("send_in_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = W'($urandom);
  endtask

  task automatic wait_ov(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_out_valid");
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) bound_fail("wait_handshake");
  endtask

  // Directed case with hand-computed expectations.
  task automatic directed(input logic [W-1:0] v, input int er, input int erm);
    bit ok;
    send(v);
    wait_ov(ok);
    if (ok) begin
      check($sformatf("root_x%0d", v), longint'(root), longint'(er));
`ifdef SQRT_REM_EN
      check($sformatf("rem_x%0d", v), longint'(rem), longint'(erm));
`else
      if (erm < 0) check("rem_arg", 0, 1);
`endif
    end
    wait_idle();
  endtask

  initial begin
    bit ok;
    int k;
    logic [W-1:0] v;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_root", longint'(root), 0);
`ifdef SQRT_REM_EN
    check("rst_rem", longint'(rem), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Boundaries and small values.
    directed(16'd0, 0, 0);
    directed(16'd15, 3, 6);
    directed(16'd16, 4, 0);
    directed(16'd17, 4, 1);
    directed(16'd65535, 255, 510);
    directed(16'd65025, 255, 0);

    // Back-pressure: result held for 20 cycles, input pulses ignored.
    out_drv = 1'b0;
    send(16'd50000);
    wait_ov(ok);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      x        = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_root", longint'(root), 223);
`ifdef SQRT_REM_EN
      check("bp_rem", longint'(rem), 271);
`endif
      check("bp_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_drv  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", longint'(out_valid), 0);
    check("bp_release_in_ready", longint'(in_ready), 1);

    // Back-to-back: 100 then 99 with the second radicand offered throughout.
    send(16'd100);
    in_valid = 1'b1;
    x        = 16'd99;
    wait_ov(ok);
    if (ok) begin
      check("b2b_root_100", longint'(root), 10);
`ifdef SQRT_REM_EN
      check("b2b_rem_100", longint'(rem), 0);
`endif
      @(negedge clk);
      check("b2b_in_ready_rise", longint'(in_ready), 1);
      check("b2b_out_valid_drop", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_ov(ok);
    if (ok) begin
      check("b2b_root_99", longint'(root), 9);
`ifdef SQRT_REM_EN
      check("b2b_rem_99", longint'(rem), 18);
`endif
    end
    wait_idle();

    // Reset during the fourth CALC cycle abandons the computation.
    send(16'd40000);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    t_q.delete();
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    check("midrst_root", longint'(root), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("midrst_no_out_valid", longint'(out_valid), 0);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("midrst_in_ready");
    directed(16'd144, 12, 0);

    // Random sweep with random consumer back-pressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(1, 255);
      case ($urandom_range(0, 3))
        0:       v = W'(k * k);
        1:       v = W'(k * k - 1);
        default: v = W'($urandom);
      endcase
      send(v);
      wait_ov(ok);
      wait_idle();
    end
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    check("scoreboard_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
